// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues instruction-memory reads, buffers words with their PCs and
// hands them to decode. Optional macro FETCH_JUMP_PREDECODE_EN redirects early on JMP/JAL.
module instr_fetch #(
  parameter int                   WORD_SIZE  = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] req_pc;
  logic [WORD_SIZE-1:0] mem_inst [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] mem_pc   [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic                 deq;
  logic                 enq;
  logic                 decide;
  logic                 space;
  logic [CW-1:0]        cnt_after_deq;
  logic [CW-1:0]        cnt_after_enq;
  logic [WORD_SIZE-1:0] next_addr;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? mem_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : '0;
  assign i_readM    = (state != IDLE);
  assign i_address  = req_pc;

  always_comb begin
    deq           = inst_valid && inst_ready;
    enq           = (state == REQ) && i_inputReady && !redirect;
    cnt_after_deq = count - CW'(deq);
    cnt_after_enq = cnt_after_deq + CW'(enq);
    space         = cnt_after_enq < CW'(FIFO_DEPTH);
    // A new fetch decision is made when idle or when the outstanding request completes.
    decide        = (state == IDLE) || i_inputReady;
    next_addr     = fetch_pc;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (enq && (i_data[15:12] == 4'd9 || i_data[15:12] == 4'd10))
      next_addr = {req_pc[WORD_SIZE-1:12], i_data[11:0]};
`endif
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_inst[wr_ptr] <= i_data;
      mem_pc[wr_ptr]   <= req_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (state != IDLE && !i_inputReady) begin
        // Old request still on the bus: wait out its response before refetching.
        state    <= DROP;
        fetch_pc <= redirect_pc;
      end else begin
        state    <= REQ;
        req_pc   <= redirect_pc;
        fetch_pc <= redirect_pc + ONE;
      end
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= cnt_after_enq;
      if (decide) begin
        if (space) begin
          state    <= REQ;
          req_pc   <= next_addr;
          fetch_pc <= next_addr + ONE;
        end else begin
          state    <= IDLE;
          fetch_pc <= next_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      assert (cnt_after_deq < CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 16-bit pipelined CPU: the producer end of the instruction stream that the control decoder consumes. It issues reads on the instruction-memory handshake (`i_readM`/`i_inputReady`) and buffers returned words with their PCs in a small FIFO. It presents them to decode with a valid/ready handshake and applies PC redirects (jumps, JPR/JRL, taken branches) from the datapath, discarding stale in-flight responses.

## Interface
- `WORD_SIZE`, 16, instruction/address width
- `RESET_PC`, 16'h0000, first fetch address after reset
- `FIFO_DEPTH`, 2, buffer entries; power of two, ≥2
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `i_readM`  out  1  instruction-memory read request
- `i_address`  out  WORD_SIZE  read address; stable while `i_readM`=1
- `i_data`  in  WORD_SIZE  read data; valid when `i_inputReady`=1
- `i_inputReady`  in  1  one-cycle response strobe
- `inst`  out  WORD_SIZE  FIFO head instruction
- `inst_pc`  out  WORD_SIZE  PC of `inst`
- `inst_valid`  out  1  FIFO non-empty
- `inst_ready`  in  1  decode accepts head this cycle
- `redirect`  in  1  PC redirect request (one cycle)
- `redirect_pc`  in  WORD_SIZE  redirect target

## Operation
- Registers: `fetch_pc`, `req_pc`, FIFO (`inst`/`pc` pairs, read/write pointers, count), state.
- States: IDLE (no request outstanding), REQ (request outstanding, response kept), DROP (request outstanding, response discarded).
- IDLE → REQ when entries free after this cycle's dequeue > 0: `req_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+1. Addresses are word addresses and wrap 16'hFFFF→16'h0000.
- REQ with `i_inputReady`: enqueue {`i_data`, `req_pc`}. Go to REQ at `fetch_pc` when space remains, counting enqueue and dequeue in the same cycle; otherwise go to IDLE.
- `i_readM`=1 in REQ and DROP; `i_address`=`req_pc`.
- Dequeue when `inst_valid`&&`inst_ready`. Enqueue into a full FIFO is impossible by construction; the FIFO assertion flags it.
- Redirect has priority over all other events:
  - FIFO cleared and `fetch_pc`←`redirect_pc`.
  - In IDLE: go to REQ at `redirect_pc` on the next cycle.
  - In REQ without `i_inputReady`: go to DROP. The old address stays on the bus until the response arrives, then REQ at `fetch_pc`.
  - In REQ or DROP with `i_inputReady` in the same cycle: response discarded, then REQ at `redirect_pc`.
  - In DROP: `fetch_pc` is overwritten and the state stays DROP.
  - A dequeue in the redirect cycle is still a completed handshake for decode.

## Timing
- Reset values: `i_readM`=0, `i_address`=0, `inst`=0, `inst_pc`=0, `inst_valid`=0, FIFO empty, state IDLE, `fetch_pc`=`RESET_PC`.
- First request: `i_readM`=1 with `RESET_PC` on the first cycle after `reset` deasserts.
- Response to decode: a word strobed in cycle N appears at `inst` with `inst_valid`=1 in cycle N+1.
- Back-to-back requests: the next request is issued in cycle N+1. Memory with zero-wait strobes gives one instruction per 2 cycles. Throughput is bounded by memory, not FIFO.
- Redirect in cycle N: `inst_valid`=0 in N+1. The new address appears in N+1 unless a stale request is still outstanding.
- `reset` mid-transaction: returns to reset values immediately. A stale strobe after reset is ignored because the state is IDLE.

## Configuration
- `FETCH_JUMP_PREDECODE_EN` defined: on enqueue, opcode `i_data[15:12]` 9 (JMP) or 10 (JAL) triggers an internal redirect.
  - Target is {`req_pc[15:12]`, `i_data[11:0]`}.
  - The jump word itself is still enqueued, since JAL needs its link write.
  - Sequential fetch stops, the same cycle counts as an IDLE→REQ decision at the target, and no stale words follow.
  - An external `redirect` in the same cycle overrides the internal one.
- Undefined: no predecode. All control transfers come from `redirect`; words after a jump are fetched and later flushed.

## Test plan
- Reset, memory always strobing next cycle → `i_address` 0,1,2,3 and `inst_pc` 0,1,2 in order, one per 2 cycles.
- Hold `inst_ready`=0 with `FIFO_DEPTH`=2 → exactly 2 entries filled, then `i_readM`=0. Raise ready → fetch resumes at PC 2, no word lost or duplicated.
- Redirect to 16'h0040 while a request to 5 is outstanding (strobe 3 cycles later) → the word for 5 is never presented, then request 16'h0040 and `inst_pc`=16'h0040.
- Redirect and `i_inputReady` in the same cycle → strobed word dropped, next cycle `i_address`=`redirect_pc`.
- `fetch_pc`=16'hFFFF → next request address 16'h0000.
- Macro defined, word 16'h9123 fetched at PC 16'h2005 → it is presented, next request is 16'h2123, and no fetch of 16'h2006 occurs. Without the macro, 16'h2006 is requested.
